// File: rtl/mole_round_controller_if.sv
// Signal bundle between the whack-a-mole round controller and its surroundings:
// the seconds square wave, player inputs and the display-facing outputs.
interface mole_round_controller_if;
   logic       sec_clk;
   logic       start;
   logic [7:0] whack;
   logic [7:0] mole;
   logic [7:0] score;
   logic [7:0] time_left;
   logic       playing;
   logic       game_over;

   modport master (
      output sec_clk, start, whack,
      input  mole, score, time_left, playing, game_over
   );

   modport slave (
      input  sec_clk, start, whack,
      output mole, score, time_left, playing, game_over
   );
endinterface

// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: seconds tick extraction, mole selection,
// BCD round timer and BCD score.
//
//   state  | meaning
//   -------+------------------------------------------------------
//   S_IDLE | after reset, waiting for start; all outputs zero
//   S_PLAY | round running: ticks count down, moles pop, hits score
//   S_OVER | round finished; score held, waiting for start
module mole_round_controller #(
   parameter int unsigned GAME_SECONDS = 30,
   parameter int unsigned MOLE_SECONDS = 2,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic                    clock,
   input  logic                    reset,
   mole_round_controller_if.slave  bus
);

   localparam logic [7:0] GAME_BCD  = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};
   localparam logic [3:0] MOLE_LOAD = 4'(MOLE_SECONDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       sync1, sync2, sync3;
   logic       tick;
   logic [7:0] lfsr;
   logic       lfsr_fb;
   logic [7:0] whack_prev;
   logic [7:0] press;
   logic [2:0] idx_raw, sel_idx;
   logic [7:0] sel_onehot;

   logic [7:0] mole_q, mole_d;
   logic [7:0] score_q, score_d;
   logic [7:0] time_q, time_d;
   logic [3:0] timer_q, timer_d;
   logic [2:0] prev_q, prev_d;
   logic       playing_q, game_over_q;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v == 8'h99) return v;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   // sec_clk is asynchronous data: two flops to resolve it, a third for edge detect
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= bus.sec_clk;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign tick = sync2 & ~sync3;

   // x^8+x^6+x^5+x^4+1, free-running regardless of state
   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr       <= LFSR_SEED;
         whack_prev <= 8'h00;
      end else begin
         lfsr       <= {lfsr[6:0], lfsr_fb};
         whack_prev <= bus.whack;
      end
   end

   assign press = bus.whack & ~whack_prev;

   // Bump a repeated index to the next hole so the same hole never lights twice running
   assign idx_raw    = lfsr[2:0];
   assign sel_idx    = (idx_raw == prev_q) ? idx_raw + 3'd1 : idx_raw;
   assign sel_onehot = 8'b0000_0001 << sel_idx;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mole_d  = mole_q;
      score_d = score_q;
      time_d  = time_q;
      timer_d = timer_q;
      prev_d  = prev_q;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (bus.start) begin
               state_d = S_PLAY;
               time_d  = GAME_BCD;
               score_d = 8'h00;
               timer_d = MOLE_LOAD;
               mole_d  = sel_onehot;
               prev_d  = sel_idx;
            end
         end
         S_PLAY: begin
            if ((press & mole_q) != 8'h00) begin
               score_d = bcd_inc(score_q);
               mole_d  = 8'h00;
            end
            // a tick overrides the hit's mole clear, so the new mole still appears
            if (tick) begin
               if (time_q == 8'h01) begin
                  state_d = S_OVER;
                  time_d  = 8'h00;
                  mole_d  = 8'h00;
               end else begin
                  time_d = bcd_dec(time_q);
                  if (timer_q == 4'd1) begin
                     timer_d = MOLE_LOAD;
                     mole_d  = sel_onehot;
                     prev_d  = sel_idx;
                  end else begin
                     timer_d = timer_q - 4'd1;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mole_q      <= 8'h00;
         score_q     <= 8'h00;
         time_q      <= 8'h00;
         timer_q     <= 4'd0;
         prev_q      <= 3'd0;
         playing_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         mole_q      <= mole_d;
         score_q     <= score_d;
         time_q      <= time_d;
         timer_q     <= timer_d;
         prev_q      <= prev_d;
         playing_q   <= (state_d == S_PLAY);
         game_over_q <= (state_d == S_OVER);
      end
   end

   assign bus.mole      = mole_q;
   assign bus.score     = score_q;
   assign bus.time_left = time_q;
   assign bus.playing   = playing_q;
   assign bus.game_over = game_over_q;

endmodule
